// File: rtl/tpm_locality_arbiter_pkg.sv
// Shared TPM locality definitions: default locality count, arbiter state encodings, empty-owner index.
package tpm_locality_arbiter_pkg;

  localparam int NUM_LOC_DEFAULT = 5;
  localparam logic [2:0] LOC_NONE = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } arbState_t;

endpackage

// File: rtl/tpm_locality_arbiter_prio_encoder.sv
// Highest-set-index encoder; latency 0 (combinational); no backpressure.
// Returns index 0 with any=0 for an empty vector.
module tpm_locality_arbiter_prio_encoder #(
  parameter int W = 5
) (
  input  logic [W-1:0] vec,
  output logic [2:0]   idx,
  output logic         any
);

  always_comb begin
    idx = 3'd0;
    any = |vec;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/tpm_locality_arbiter.sv
// TPM_ACCESS locality ownership arbiter; grant 1 cycle after request, handoff 2 cycles via Release (f_abort).
// Inputs are single-cycle pulses with no backpressure; LOCALITY_TIMEOUT_EN adds an idle-owner timeout.
module tpm_locality_arbiter
  import tpm_locality_arbiter_pkg::*;
#(
  parameter int NUM_LOC        = NUM_LOC_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_LOC-1:0] a_requestUse,
  input  logic [NUM_LOC-1:0] a_relinquish,
  input  logic [NUM_LOC-1:0] a_seize,
  input  logic [NUM_LOC-1:0] a_clrSeized,
  input  logic               t_activity,
  output logic [2:0]         activeLocality,
  output logic               localityValid,
  output logic [NUM_LOC-1:0] pendingRequest,
  output logic [NUM_LOC-1:0] beenSeized,
  output logic               f_abort
);

  arbState_t          state;
  logic [NUM_LOC-1:0] arbReq, seizeCand, ownerBit, grantBit, seizeBit, activePend;
  logic [2:0]         grantIdx, seizeIdx;
  logic               grantAny, seizeAny, ownerRelease, timeoutHit;

  tpm_locality_arbiter_prio_encoder #(.W(NUM_LOC)) grantEnc (
    .vec(arbReq), .idx(grantIdx), .any(grantAny)
  );

  tpm_locality_arbiter_prio_encoder #(.W(NUM_LOC)) seizeEnc (
    .vec(seizeCand), .idx(seizeIdx), .any(seizeAny)
  );

  always_comb begin
    ownerBit  = '0;
    grantBit  = '0;
    seizeBit  = '0;
    seizeCand = '0;
    // Seize only counts as a request when nobody owns the datapath.
    arbReq = pendingRequest | a_requestUse;
    if (state == ST_IDLE) arbReq = arbReq | a_seize;
    for (int i = 0; i < NUM_LOC; i++) begin
      ownerBit[i]  = (3'(i) == activeLocality);
      grantBit[i]  = (3'(i) == grantIdx);
      seizeBit[i]  = (3'(i) == seizeIdx);
      seizeCand[i] = a_seize[i] && (3'(i) > activeLocality);
    end
    activePend   = (pendingRequest | (a_requestUse & ~ownerBit)) & ~(a_relinquish & ~ownerBit);
    ownerRelease = ((a_relinquish & ownerBit) != '0) || timeoutHit;
  end

`ifdef LOCALITY_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] idleCnt;

  // Only an owner that sits idle while others wait is timed out.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idleCnt <= '0;
    end else if (state != ST_ACTIVE || t_activity || pendingRequest == '0) begin
      idleCnt <= '0;
    end else if (idleCnt != CW'(TIMEOUT_CYCLES)) begin
      idleCnt <= idleCnt + 1'b1;
    end
  end

  assign timeoutHit = (state == ST_ACTIVE) && (idleCnt == CW'(TIMEOUT_CYCLES));
`else
  assign timeoutHit = t_activity & 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      activeLocality <= LOC_NONE;
      localityValid  <= 1'b0;
      pendingRequest <= '0;
      beenSeized     <= '0;
      f_abort        <= 1'b0;
    end else begin
      f_abort    <= 1'b0;
      beenSeized <= beenSeized & ~a_clrSeized;
      case (state)
        ST_IDLE, ST_RELEASE: begin
          pendingRequest <= arbReq & ~grantBit;
          if (grantAny) begin
            state          <= ST_ACTIVE;
            activeLocality <= grantIdx;
            localityValid  <= 1'b1;
          end else begin
            state          <= ST_IDLE;
            activeLocality <= LOC_NONE;
            localityValid  <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          pendingRequest <= activePend;
          // Seize outranks a simultaneous relinquish so the victim is still flagged.
          if (seizeAny) begin
            state          <= ST_RELEASE;
            localityValid  <= 1'b0;
            f_abort        <= 1'b1;
            beenSeized     <= (beenSeized & ~a_clrSeized) | ownerBit;
            pendingRequest <= activePend | seizeBit;
          end else if (ownerRelease) begin
            state         <= ST_RELEASE;
            localityValid <= 1'b0;
            f_abort       <= 1'b1;
          end
        end
        default: begin
          state          <= ST_IDLE;
          activeLocality <= LOC_NONE;
          localityValid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpm_locality_arbiter.sv
// Scoreboard bench for tpm_locality_arbiter: expected outputs are queued with each stimulus step.
module tb_tpm_locality_arbiter;

  localparam int NL = 5;
  localparam int TMO = 16;

  typedef struct packed {
    logic [2:0]    loc;
    logic          vld;
    logic [NL-1:0] pend;
    logic [NL-1:0] seized;
    logic          abort;
  } obs_t;

  typedef struct packed {
    logic [NL-1:0] ru;
    logic [NL-1:0] rl;
    logic [NL-1:0] sz;
    logic [NL-1:0] cs;
  } stim_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [NL-1:0] a_requestUse = '0, a_relinquish = '0, a_seize = '0, a_clrSeized = '0;
  logic          t_activity = 1'b0;
  logic [2:0]    activeLocality;
  logic          localityValid;
  logic [NL-1:0] pendingRequest, beenSeized;
  logic          f_abort;

  int   total = 0;
  int   bad = 0;
  obs_t sb[$];

  tpm_locality_arbiter #(.NUM_LOC(NL), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_requestUse(a_requestUse), .a_relinquish(a_relinquish),
    .a_seize(a_seize), .a_clrSeized(a_clrSeized), .t_activity(t_activity),
    .activeLocality(activeLocality), .localityValid(localityValid),
    .pendingRequest(pendingRequest), .beenSeized(beenSeized), .f_abort(f_abort)
  );

  always #5 clock = ~clock;

  function automatic obs_t mk(logic [2:0] loc, logic vld, logic [NL-1:0] pend, logic [NL-1:0] seized, logic abort);
    obs_t o;
    o.loc = loc; o.vld = vld; o.pend = pend; o.seized = seized; o.abort = abort;
    return o;
  endfunction

  function automatic stim_t st(logic [NL-1:0] ru, logic [NL-1:0] rl, logic [NL-1:0] sz, logic [NL-1:0] cs);
    stim_t s;
    s.ru = ru; s.rl = rl; s.sz = sz; s.cs = cs;
    return s;
  endfunction

  function automatic obs_t snap();
    obs_t o;
    o.loc = activeLocality; o.vld = localityValid; o.pend = pendingRequest;
    o.seized = beenSeized; o.abort = f_abort;
    return o;
  endfunction

  // Drive one cycle of pulses, clock it in, sample 1ns after the edge.
  task automatic apply(stim_t s);
    @(negedge clock);
    a_requestUse = s.ru; a_relinquish = s.rl; a_seize = s.sz; a_clrSeized = s.cs;
    @(posedge clock);
    #1;
    a_requestUse = '0; a_relinquish = '0; a_seize = '0; a_clrSeized = '0;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    sb.push_back(mk(3'd0, 1'b0, 5'b0, 5'b0, 1'b0));
    repeat (2) @(posedge clock);
    #1;
    got = snap(); exp = sb.pop_front(); total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL reset_in: got loc=%0d vld=%b pend=%b seized=%b abort=%b want loc=%0d vld=%b pend=%b seized=%b abort=%b",
               got.loc, got.vld, got.pend, got.seized, got.abort, exp.loc, exp.vld, exp.pend, exp.seized, exp.abort);
    end
    @(negedge clock);
    reset_n = 1'b1;
    sb.push_back(mk(3'd0, 1'b0, 5'b0, 5'b0, 1'b0));
    apply(st(5'b0, 5'b0, 5'b0, 5'b0));
    got = snap(); exp = sb.pop_front(); total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL reset_idle: got loc=%0d vld=%b pend=%b seized=%b abort=%b want loc=%0d vld=%b pend=%b seized=%b abort=%b",
               got.loc, got.vld, got.pend, got.seized, got.abort, exp.loc, exp.vld, exp.pend, exp.seized, exp.abort);
    end
  endtask

  task automatic test_handoff();
    stim_t s[$];
    obs_t  got, exp;
    s.push_back(st(5'b00100, 0, 0, 0)); sb.push_back(mk(3'd2, 1, 5'b00000, 0, 0));
    s.push_back(st(5'b10001, 0, 0, 0)); sb.push_back(mk(3'd2, 1, 5'b10001, 0, 0));
    s.push_back(st(0, 5'b00100, 0, 0)); sb.push_back(mk(3'd2, 0, 5'b10001, 0, 1));
    s.push_back(st(0, 0, 0, 0));        sb.push_back(mk(3'd4, 1, 5'b00001, 0, 0));
    s.push_back(st(0, 5'b10000, 0, 0)); sb.push_back(mk(3'd4, 0, 5'b00001, 0, 1));
    s.push_back(st(0, 0, 0, 0));        sb.push_back(mk(3'd0, 1, 5'b00000, 0, 0));
    s.push_back(st(0, 5'b00001, 0, 0)); sb.push_back(mk(3'd0, 0, 5'b00000, 0, 1));
    s.push_back(st(0, 0, 0, 0));        sb.push_back(mk(3'd0, 0, 5'b00000, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      got = snap(); exp = sb.pop_front(); total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL handoff[%0d]: got loc=%0d vld=%b pend=%b seized=%b abort=%b want loc=%0d vld=%b pend=%b seized=%b abort=%b",
                 i, got.loc, got.vld, got.pend, got.seized, got.abort, exp.loc, exp.vld, exp.pend, exp.seized, exp.abort);
      end
    end
  endtask

  task automatic test_seize();
    stim_t s[$];
    obs_t  got, exp;
    s.push_back(st(5'b00010, 0, 0, 0));       sb.push_back(mk(3'd1, 1, 0, 5'b00000, 0));
    s.push_back(st(0, 0, 5'b01000, 0));       sb.push_back(mk(3'd1, 0, 5'b01000, 5'b00010, 1));
    s.push_back(st(0, 0, 0, 0));              sb.push_back(mk(3'd3, 1, 0, 5'b00010, 0));
    s.push_back(st(0, 0, 0, 5'b00010));       sb.push_back(mk(3'd3, 1, 0, 5'b00000, 0));
    s.push_back(st(0, 0, 5'b00110, 0));       sb.push_back(mk(3'd3, 1, 0, 5'b00000, 0));
    s.push_back(st(0, 5'b01000, 5'b10000, 0)); sb.push_back(mk(3'd3, 0, 5'b10000, 5'b01000, 1));
    s.push_back(st(0, 0, 0, 0));              sb.push_back(mk(3'd4, 1, 0, 5'b01000, 0));
    s.push_back(st(0, 0, 0, 5'b01000));       sb.push_back(mk(3'd4, 1, 0, 5'b00000, 0));
    s.push_back(st(0, 5'b10000, 0, 0));       sb.push_back(mk(3'd4, 0, 0, 5'b00000, 1));
    s.push_back(st(0, 0, 0, 0));              sb.push_back(mk(3'd0, 0, 0, 5'b00000, 0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      got = snap(); exp = sb.pop_front(); total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL seize[%0d]: got loc=%0d vld=%b pend=%b seized=%b abort=%b want loc=%0d vld=%b pend=%b seized=%b abort=%b",
                 i, got.loc, got.vld, got.pend, got.seized, got.abort, exp.loc, exp.vld, exp.pend, exp.seized, exp.abort);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    obs_t  got, exp;
    s.push_back(st(5'b00001, 0, 0, 0)); sb.push_back(mk(3'd0, 1, 0, 0, 0));
    s.push_back(st(0, 5'b00001, 0, 0)); sb.push_back(mk(3'd0, 0, 0, 0, 1));
    s.push_back(st(5'b01000, 0, 0, 0)); sb.push_back(mk(3'd3, 1, 0, 0, 0));
    s.push_back(st(5'b01000, 0, 0, 0)); sb.push_back(mk(3'd3, 1, 0, 0, 0));
    s.push_back(st(5'b00100, 0, 0, 0)); sb.push_back(mk(3'd3, 1, 5'b00100, 0, 0));
    s.push_back(st(0, 5'b00100, 0, 0)); sb.push_back(mk(3'd3, 1, 5'b00000, 0, 0));
    s.push_back(st(0, 5'b01000, 0, 0)); sb.push_back(mk(3'd3, 0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0));        sb.push_back(mk(3'd0, 0, 0, 0, 0));
    for (int i = 0; i < s.size(); i++) begin
      apply(s[i]);
      got = snap(); exp = sb.pop_front(); total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL b2b[%0d]: got loc=%0d vld=%b pend=%b seized=%b abort=%b want loc=%0d vld=%b pend=%b seized=%b abort=%b",
                 i, got.loc, got.vld, got.pend, got.seized, got.abort, exp.loc, exp.vld, exp.pend, exp.seized, exp.abort);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t got, exp;
    int   waited;
    apply(st(5'b00001, 0, 0, 0));
    apply(st(5'b00100, 0, 0, 0));
`ifdef LOCALITY_TIMEOUT_EN
    // Counter restarts on the request edge, counts to TMO, then one more edge enters Release.
    waited = 0;
    while (f_abort !== 1'b1 && waited < 3 * TMO) begin
      apply(st(0, 0, 0, 0));
      waited++;
    end
    total++;
    if (waited !== TMO + 1) begin
      bad++;
      $display("FAIL timeout_cycles: got %0d cycles, want %0d", waited, TMO + 1);
    end
    sb.push_back(mk(3'd2, 1, 0, 0, 0));
    apply(st(0, 0, 0, 0));
`else
    for (int i = 0; i < 3 * TMO; i++) begin
      sb.push_back(mk(3'd0, 1, 5'b00100, 0, 0));
      apply(st(0, 0, 0, 0));
      got = snap(); exp = sb.pop_front(); total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL hold[%0d]: got loc=%0d vld=%b pend=%b abort=%b want loc=%0d vld=%b pend=%b abort=%b",
                 i, got.loc, got.vld, got.pend, got.abort, exp.loc, exp.vld, exp.pend, exp.abort);
      end
    end
    sb.push_back(mk(3'd2, 1, 0, 0, 0));
    apply(st(0, 5'b00001, 0, 0));
    apply(st(0, 0, 0, 0));
`endif
    got = snap(); exp = sb.pop_front(); total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL timeout_owner: got loc=%0d vld=%b pend=%b seized=%b abort=%b want loc=%0d vld=%b pend=%b seized=%b abort=%b",
               got.loc, got.vld, got.pend, got.seized, got.abort, exp.loc, exp.vld, exp.pend, exp.seized, exp.abort);
    end
    apply(st(0, 5'b00100, 0, 0));
    apply(st(0, 0, 0, 0));
  endtask

  task automatic test_reset_release();
    obs_t got, exp;
    apply(st(5'b00011, 0, 0, 0));
    sb.push_back(mk(3'd1, 0, 5'b00001, 0, 1));
    apply(st(0, 5'b00010, 0, 0));
    got = snap(); exp = sb.pop_front(); total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL rr_release: got loc=%0d vld=%b pend=%b abort=%b want loc=%0d vld=%b pend=%b abort=%b",
               got.loc, got.vld, got.pend, got.abort, exp.loc, exp.vld, exp.pend, exp.abort);
    end
    // Still inside the Release cycle: reset must clear outputs without a clock edge.
    sb.push_back(mk(3'd0, 0, 0, 0, 0));
    reset_n = 1'b0;
    #1;
    got = snap(); exp = sb.pop_front(); total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL rr_async: got loc=%0d vld=%b pend=%b abort=%b want loc=%0d vld=%b pend=%b abort=%b",
               got.loc, got.vld, got.pend, got.abort, exp.loc, exp.vld, exp.pend, exp.abort);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(3'd0, 0, 0, 0, 0));
      apply(st(0, 0, 0, 0));
      got = snap(); exp = sb.pop_front(); total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL rr_after[%0d]: got loc=%0d vld=%b pend=%b abort=%b want loc=%0d vld=%b pend=%b abort=%b",
                 i, got.loc, got.vld, got.pend, got.abort, exp.loc, exp.vld, exp.pend, exp.abort);
      end
    end
  endtask

  initial begin
    test_reset();
    test_handoff();
    test_seize();
    test_back_to_back();
    test_timeout();
    test_reset_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tpm_locality_arbiter.md
Name: tpm_locality_arbiter

Overview:
- Arbitrates ownership of the FRS/FIFO datapath among the 5 TPM localities, implementing TPM_ACCESS semantics: requestUse, activeLocality relinquish, seize and beenSeized.
- Sits between the TPM_ACCESS register decode and the FRS/fifo_buffer.
- Drives the active-locality qualifier used by FRS to accept or drop transactions.
- Pulses f_abort to flush the FIFO buffer on every ownership change.

Parameters:
- NUM_LOC, 5, number of localities; index 0..NUM_LOC-1; higher index = higher priority.
- TIMEOUT_CYCLES, 1000000, idle-hold limit used only when LOCALITY_TIMEOUT_EN is defined.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- a_requestUse  in  NUM_LOC  one-cycle pulses; locality i wrote TPM_ACCESS.requestUse=1.
- a_relinquish  in  NUM_LOC  one-cycle pulses; locality i wrote TPM_ACCESS.activeLocality=1 (release).
- a_seize  in  NUM_LOC  one-cycle pulses; locality i wrote TPM_ACCESS.Seize=1.
- a_clrSeized  in  NUM_LOC  one-cycle pulses; locality i wrote TPM_ACCESS.beenSeized=1 (clear).
- t_activity  in  1  FRS transaction in progress; restarts the timeout counter.
- activeLocality  out  3  index of the owning locality; 0 when none.
- localityValid  out  1  an owner exists.
- pendingRequest  out  NUM_LOC  latched requestUse bits (TPM_ACCESS.pendingRequest source).
- beenSeized  out  NUM_LOC  sticky seized flags.
- f_abort  out  1  one-cycle pulse to fifo_buffer/FRS on every release or seize.

Behaviour:
- Reset values: activeLocality=0, localityValid=0, pendingRequest=0, beenSeized=0, f_abort=0. State=Idle. Reset mid-operation discards ownership immediately and emits no abort pulse.
- All inputs are sampled on posedge clock. All outputs are registered.
- States: Idle, Active, Release.
- Idle:
  - req = pendingRequest | a_requestUse | a_seize.
  - If req != 0: next edge goes to Active, owner = highest set index, that bit cleared from pendingRequest, localityValid=1.
  - Grant latency is 1 cycle after the request pulse.
- Active, owner k:
  - a_requestUse[k] is ignored.
  - a_requestUse[i], i!=k, sets pendingRequest[i].
  - a_relinquish[i], i!=k, clears pendingRequest[i] only.
  - a_relinquish[k]: go to Release.
  - a_seize[j] with j>k: go to Release; beenSeized[k] <= 1; pendingRequest[j] <= 1.
  - a_seize[j] with j<=k is ignored.
  - If several seizes arrive, the highest j wins.
  - Seize and relinquish[k] in the same cycle: treated as seize, so beenSeized[k] is set.
- Release:
  - f_abort=1 for exactly this cycle; localityValid=0; activeLocality holds the old value.
  - Next edge: if pendingRequest|a_requestUse != 0, go to Active with the highest pending; otherwise go to Idle.
  - Handoff latency from relinquish pulse to new owner: 2 cycles.
- a_requestUse arriving in the Release cycle is latched and takes part in that cycle's arbitration.
- beenSeized[i]: set by seize as above; cleared by a_clrSeized[i]. If set and clear coincide, set wins.
- activeLocality is 3 bits wide regardless of NUM_LOC (NUM_LOC<=8). Request bits above NUM_LOC-1 do not exist.

Optional Feature:
- LOCALITY_TIMEOUT_EN defined:
  - Counter of width $clog2(TIMEOUT_CYCLES+1).
  - Clears whenever the state is not Active, or t_activity=1, or pendingRequest==0.
  - Otherwise increments, saturating.
  - Reaching TIMEOUT_CYCLES forces Release as if a_relinquish[owner] were asserted; beenSeized is not set.
- Undefined: no counter is built; ownership is held indefinitely.

Decomposition:
- Shared package/include (tpm_io_defs): NUM_LOC default, state encodings (Idle=0, Active=1, Release=2), LOC_NONE=3'd0.
- One natural sub-module: prio_encoder (NUM_LOC-bit vector -> 3-bit highest-set index plus any flag). It is used for both grant and seize selection.

Test Plan:
- Reset, then a_requestUse=5'b00100 -> 1 cycle later activeLocality=2, localityValid=1, pendingRequest=0, f_abort never pulsed.
- Owner 2; a_requestUse=5'b10001 -> pendingRequest=5'b10001; then a_relinquish[2] -> f_abort one cycle, then activeLocality=4, pendingRequest=5'b00001.
- Owner 1; a_seize[3] -> Release with f_abort=1, beenSeized=5'b00010, then activeLocality=3; a_clrSeized[1] -> beenSeized=0.
- Owner 3; a_seize[1] and a_seize[2] -> no state change, f_abort stays 0; same-cycle a_seize[4] + a_relinquish[3] -> beenSeized[3]=1, owner becomes 4.
- Owner 0 with pendingRequest[2]=1, t_activity=0, TIMEOUT_CYCLES=16 (macro defined) -> Release after 16 cycles, owner 2, beenSeized unchanged; with macro undefined, owner stays 0.
- Assert reset_n=0 during the Release cycle -> all outputs 0 asynchronously; after release, Idle with no stale grant.
